// File: rtl/data_memory_responder.sv
// Responder for the core's data-memory port: one outstanding load or store,
// byte-masked writes into a word array, raw word returned after WAIT_STATES cycles.
module data_memory_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memReq,
  input  logic        memWe,
  input  logic [31:0] memAddr,
  input  logic [31:0] memWdata,
  input  logic [3:0]  memWMask,
  output logic        memReady,
  output logic        memRvalid,
  output logic [31:0] memRdata,
  output logic        memErr
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN      = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

  stateT       state, nextState;
  logic [3:0]  waitCount;
  logic        weReg;
  logic [31:0] addrReg, wdataReg;
  logic [3:0]  maskReg;
  logic [31:0] rdataReg;
  logic        errReg;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept, commit, bypass;
  logic          opWe;
  logic [31:0]   opAddr, opWdata, opOff;
  logic [3:0]    opMask;
  logic          opInRange;
  logic [AW-1:0] opIndex;

  assign accept = (state == IDLE) && memReq;
  assign commit = (nextState == RESP) && !reset;

  // With zero wait states the commit edge is the acceptance edge, so the
  // operation must come straight from the inputs instead of the latches.
  assign bypass    = (state == IDLE);
  assign opWe      = bypass ? memWe    : weReg;
  assign opAddr    = bypass ? memAddr  : addrReg;
  assign opWdata   = bypass ? memWdata : wdataReg;
  assign opMask    = bypass ? memWMask : maskReg;
  assign opOff     = opAddr - BASE_ADDR;
  assign opInRange = (opOff < SPAN);
  assign opIndex   = opOff[AW+1:2];

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (memReq) nextState = (WAIT_STATES > 0) ? WAIT : RESP;
      WAIT:    if (waitCount <= 4'd1) nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      waitCount <= 4'd0;
      weReg     <= 1'b0;
      addrReg   <= 32'h0;
      wdataReg  <= 32'h0;
      maskReg   <= 4'h0;
      rdataReg  <= 32'h0;
      errReg    <= 1'b0;
    end else begin
      state <= nextState;
      if (accept) begin
        weReg     <= memWe;
        addrReg   <= memAddr;
        wdataReg  <= memWdata;
        maskReg   <= memWMask;
        waitCount <= WAIT_LOAD;
      end else if (state == WAIT) begin
        waitCount <= waitCount - 4'd1;
      end
      if (commit) begin
        rdataReg <= (!opWe && opInRange) ? mem[opIndex] : 32'h0;
        errReg   <= !opInRange;
      end
    end
  end

  // Array contents survive reset; only the in-flight write is cancelled.
  always_ff @(posedge clk) begin
    if (commit && opWe && opInRange) begin
      for (int i = 0; i < 4; i++) begin
        if (opMask[i]) mem[opIndex][8*i +: 8] <= opWdata[8*i +: 8];
      end
    end
  end

  assign memReady  = (state == IDLE) && !reset;
  assign memRvalid = (state == RESP);
  assign memRdata  = (state == RESP) ? rdataReg : 32'h0;
  assign memErr    = (state == RESP) && errReg;

endmodule
